// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with count, almost flags, sticky errors and sync clear; FIFO_FWFT_EN selects FWFT reads.
// Latency: registered read gives pop_data one cycle after the accepting edge, FWFT presents the head with zero latency.
// Backpressure: push is refused when full unless a pop is accepted in the same cycle; refused push/pop set sticky flags.
module fifo_sync_param #(
  parameter int DATA_WIDTH             = 8,
  parameter int INDEX_WIDTH            = 2,
  parameter int ALMOST_FULL_THRESHOLD  = 2,
  parameter int ALMOST_EMPTY_THRESHOLD = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  pop_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [INDEX_WIDTH:0]  count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << INDEX_WIDTH;
  localparam int PTR_W = INDEX_WIDTH + 1;
  localparam logic [PTR_W-1:0] DEPTH_LVL = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] AF_LVL    = PTR_W'(DEPTH - ALMOST_FULL_THRESHOLD);
  localparam logic [PTR_W-1:0] AE_LVL    = PTR_W'(ALMOST_EMPTY_THRESHOLD);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  flush;
  logic                  pop_acc;
  logic                  push_acc;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count        = wr_ptr - rd_ptr;
  assign empty        = (count == '0);
  assign full         = (count == DEPTH_LVL);
  assign almost_full  = (count >= AF_LVL);
  assign almost_empty = (count <= AE_LVL);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign flush    = rst | clear;
  assign pop_acc  = pop & ~empty & ~flush;
  assign push_acc = push & (~full | pop_acc) & ~flush;

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !push_acc) overflow_q  <= 1'b1;
      if (pop && !pop_acc)   underflow_q <= 1'b1;
    end
  end

  // Storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr[INDEX_WIDTH-1:0]] <= push_data;
  end

`ifdef FIFO_FWFT_EN
  assign pop_valid = ~empty;
  assign pop_data  = mem[rd_ptr[INDEX_WIDTH-1:0]];
`else
  logic [DATA_WIDTH-1:0] pop_data_q;
  logic                  pop_valid_q;

  always_ff @(posedge clk) begin
    if (flush) begin
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
    end else begin
      pop_valid_q <= pop_acc;
      if (pop_acc) pop_data_q <= mem[rd_ptr[INDEX_WIDTH-1:0]];
    end
  end

  assign pop_valid = pop_valid_q;
  assign pop_data  = pop_data_q;
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed and random checks of fifo_sync_param against a queue-based reference model.
module tb_fifo_sync_param;

  localparam int DW    = 8;
  localparam int IW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          push = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic          pop = 1'b0;
  logic [DW-1:0] pop_data;
  logic          pop_valid;
  logic          full, empty, almost_full, almost_empty;
  logic [IW:0]   count;
  logic          overflow, underflow;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] q[$];
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;
  logic          m_pv  = 1'b0;
  logic [DW-1:0] m_pd  = '0;

  fifo_sync_param #(
    .DATA_WIDTH(DW), .INDEX_WIDTH(IW),
    .ALMOST_FULL_THRESHOLD(2), .ALMOST_EMPTY_THRESHOLD(2)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .push(push), .push_data(push_data),
    .pop(pop), .pop_data(pop_data), .pop_valid(pop_valid), .full(full),
    .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    int n;
    n = q.size();
    chk({tag, ":count"}, 32'(count), 32'(n));
    chk({tag, ":full"}, 32'(full), 32'(n == DEPTH));
    chk({tag, ":empty"}, 32'(empty), 32'(n == 0));
    chk({tag, ":afull"}, 32'(almost_full), 32'(n >= DEPTH - 2));
    chk({tag, ":aempty"}, 32'(almost_empty), 32'(n <= 2));
    chk({tag, ":ovf"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ":udf"}, 32'(underflow), 32'(m_udf));
`ifdef FIFO_FWFT_EN
    chk({tag, ":pv"}, 32'(pop_valid), 32'(n != 0));
    if (n != 0) chk({tag, ":pd"}, 32'(pop_data), 32'(q[0]));
`else
    chk({tag, ":pv"}, 32'(pop_valid), 32'(m_pv));
    chk({tag, ":pd"}, 32'(pop_data), 32'(m_pd));
`endif
  endtask

  // Drive one cycle of inputs, advance the model across the edge, check at the next falling edge.
  task automatic step(input string tag, input logic rs, input logic cl,
                      input logic pu, input logic [DW-1:0] d, input logic po);
    logic pa, pua;
    rst = rs; clear = cl; push = pu; push_data = d; pop = po;
    @(posedge clk);
    if (rs || cl) begin
      q.delete();
      m_ovf = 1'b0; m_udf = 1'b0; m_pv = 1'b0; m_pd = '0;
    end else begin
      pa  = po && (q.size() > 0);
      pua = pu && ((q.size() < DEPTH) || pa);
      if (po && !pa) m_udf = 1'b1;
      if (pu && !pua) m_ovf = 1'b1;
      m_pv = pa;
      if (pa) m_pd = q.pop_front();
      if (pua) q.push_back(d);
    end
    @(negedge clk);
    check_model(tag);
  endtask

  initial begin
    @(negedge clk);
    step("reset", 1, 0, 0, 8'h00, 0);
    step("reset", 1, 0, 1, 8'h77, 1);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_aempty", 32'(almost_empty), 32'd1);

    // 1: fill to full, then overflow
    for (int i = 0; i < 4; i++) begin
      step("t1_push", 0, 0, 1, DW'(8'h11 * (i + 1)), 0);
      chk("t1_count", 32'(count), 32'(i + 1));
      chk("t1_afull", 32'(almost_full), 32'(i >= 1));
    end
    chk("t1_full", 32'(full), 32'd1);
    step("t1_ovf", 0, 0, 1, 8'h55, 0);
    chk("t1_count_ovf", 32'(count), 32'd4);
    chk("t1_ovf_flag", 32'(overflow), 32'd1);

    // 2: drain with one extra pop
    for (int i = 0; i < 5; i++) begin
      step("t2_pop", 0, 0, 0, 8'h00, 1);
`ifndef FIFO_FWFT_EN
      if (i < 4) chk("t2_pd", 32'(pop_data), 32'(8'h11 * (i + 1)));
      chk("t2_pv", 32'(pop_valid), 32'(i < 4));
`endif
    end
    chk("t2_empty", 32'(empty), 32'd1);
    chk("t2_udf", 32'(underflow), 32'd1);
    step("t2_clear", 0, 1, 0, 8'h00, 0);

    // 3: wrap-around, never above three entries
    for (int v = 0; v < 3; v++) step("t3_fill", 0, 0, 1, DW'(v), 0);
    for (int v = 3; v < 10; v++) step("t3_pp", 0, 0, 1, DW'(v), 1);
    for (int i = 0; i < 3; i++) begin
      step("t3_drain", 0, 0, 0, 8'h00, 1);
`ifndef FIFO_FWFT_EN
      chk("t3_pd", 32'(pop_data), 32'(7 + i));
`endif
    end
    chk("t3_ovf", 32'(overflow), 32'd0);
    chk("t3_udf", 32'(underflow), 32'd0);

    // 4: simultaneous push and pop when full
    for (int i = 1; i <= 4; i++) step("t4_fill", 0, 0, 1, DW'(i), 0);
    step("t4_pp", 0, 0, 1, 8'hAA, 1);
    chk("t4_count", 32'(count), 32'd4);
    chk("t4_ovf", 32'(overflow), 32'd0);
`ifndef FIFO_FWFT_EN
    chk("t4_pd", 32'(pop_data), 32'h01);
`endif
    for (int i = 0; i < 4; i++) step("t4_pop", 0, 0, 0, 8'h00, 1);
`ifndef FIFO_FWFT_EN
    chk("t4_last", 32'(pop_data), 32'hAA);
`endif

    // 5: push and pop while empty, then clear with push held
    step("t5_pp", 0, 0, 1, 8'h5A, 1);
    chk("t5_udf", 32'(underflow), 32'd1);
    chk("t5_count", 32'(count), 32'd1);
`ifndef FIFO_FWFT_EN
    chk("t5_pv", 32'(pop_valid), 32'd0);
`endif
    step("t5_clear", 0, 1, 1, 8'h66, 0);
    chk("t5_cnt0", 32'(count), 32'd0);
    chk("t5_empty", 32'(empty), 32'd1);
    chk("t5_flags", 32'({overflow, underflow}), 32'd0);

`ifdef FIFO_FWFT_EN
    // 6: first-word-fall-through visibility
    step("t6_push", 0, 0, 1, 8'hA5, 0);
    chk("t6_pv", 32'(pop_valid), 32'd1);
    chk("t6_pd", 32'(pop_data), 32'hA5);
    step("t6_pop", 0, 0, 0, 8'h00, 1);
    chk("t6_pv_after", 32'(pop_valid), 32'd0);
`endif

    // Random traffic with phases biased toward filling and draining
    for (int i = 0; i < 600; i++) begin
      logic rs, cl, pu, po;
      int bias;
      bias = ((i / 50) % 2 == 0) ? 70 : 30;
      rs = ($urandom_range(0, 99) < 1);
      cl = ($urandom_range(0, 99) < 2);
      pu = ($urandom_range(0, 99) < bias);
      po = ($urandom_range(0, 99) < (100 - bias));
      step("rand", rs, cl, pu, DW'($urandom), po);
    end

    rst = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
